// File: rtl/uart_rx_io_pkg.sv
// Shared definitions for the UART receive IO port: register offsets,
// receiver FSM states and STATUS register bit positions.
package uart_rx_io_pkg;

    localparam logic [1:0] UART_DATA = 2'b00;
    localparam logic [1:0] UART_STAT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    localparam int STAT_NEMPTY = 0;
    localparam int STAT_FULL   = 1;
    localparam int STAT_OVR    = 2;
    localparam int STAT_FERR   = 3;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO with show-ahead output: dout always presents the
// oldest entry, so a read returns data in the same cycle it pops.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_io.sv
// Memory-mapped 8N1 UART receiver: synchronizer, bit-timing FSM, receive
// FIFO, sticky error flags and a zero-latency read mux for the CPU IO bus.
module uart_rx_io
    import uart_rx_io_pkg::*;
#(
    parameter int CLK_HZ     = 23_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        UARTCtrl,
    input  logic        ioRead,
    input  logic [1:0]  uartAddr,
    input  logic        rx,
    output logic [15:0] input_data
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BW           = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_END  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_END = BW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e   state_q;
    logic        rx_meta_q, rx_s_q;
    logic [BW-1:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        push_q, ferr_set_q;
    logic        ferr_q, ferr_d, overrun_q, overrun_d;
    logic [7:0]  fifo_dout;
    logic        fifo_full, fifo_empty;
    logic        data_rd, stat_rd, pop;

    assign data_rd = UARTCtrl & ioRead & (uartAddr == UART_DATA);
    assign stat_rd = UARTCtrl & ioRead & (uartAddr == UART_STAT);
    assign pop     = data_rd & ~fifo_empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
        end else begin
            push_q     <= 1'b0;
            ferr_set_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (!rx_s_q) state_q <= ST_START;
                end
                ST_START: begin
                    if (baud_q == HALF_END) begin
                        baud_q  <= '0;
                        state_q <= rx_s_q ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_q == BIT_END) begin
                        baud_q  <= '0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) state_q <= ST_STOP;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_q == BIT_END) begin
                        baud_q     <= '0;
                        push_q     <= rx_s_q;
                        ferr_set_q <= ~rx_s_q;
                        state_q    <= ST_IDLE;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_q),
        .pop   (pop),
        .din   (shift_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // New events take priority over the clear-on-read of STATUS.
    always_comb begin
        ferr_d    = ferr_set_q | (ferr_q & ~stat_rd);
        overrun_d = (push_q & fifo_full & ~pop) | (overrun_q & ~stat_rd);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        input_data = 16'h0000;
        if (!reset) begin
            if (data_rd && !fifo_empty) begin
                input_data = {8'h00, fifo_dout};
            end else if (stat_rd) begin
                input_data[STAT_FERR]   = ferr_q;
                input_data[STAT_OVR]    = overrun_q;
                input_data[STAT_FULL]   = fifo_full;
                input_data[STAT_NEMPTY] = ~fifo_empty;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_io.sv
// Directed bench for uart_rx_io at 16 clocks per bit: a vector table of
// frame/read records plus hand-written overrun, glitch, collision and reset cases.
module tb_uart_rx_io;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        UARTCtrl = 1'b0;
    logic        ioRead = 1'b0;
    logic [1:0]  uartAddr = 2'b00;
    logic        rx = 1'b1;
    logic [15:0] input_data;

    int n_vec = 0;
    int n_err = 0;

    uart_rx_io #(
        .CLK_HZ     (160),
        .BAUD       (10),
        .FIFO_DEPTH (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .UARTCtrl   (UARTCtrl),
        .ioRead     (ioRead),
        .uartAddr   (uartAddr),
        .rx         (rx),
        .input_data (input_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        send;
        logic [7:0]  byte_v;
        logic        stop_v;
        logic        sel;
        logic        rd;
        logic [1:0]  addr;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(negedge clock);
        rx = 1'b0;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clock);
        end
        rx = stop_bit;
        repeat (16) @(negedge clock);
        rx = 1'b1;
        repeat (24) @(negedge clock);
    endtask

    task automatic do_read(input logic sel, input logic rd, input logic [1:0] addr,
                           input logic [15:0] exp, input string name);
        @(negedge clock);
        UARTCtrl = sel;
        ioRead   = rd;
        uartAddr = addr;
        #1;
        n_vec++;
        if (input_data !== exp) begin
            n_err++;
            $display("FAIL %s: input_data=%h expected=%h", name, input_data, exp);
        end else begin
            $display("ok   %s: input_data=%h", name, input_data);
        end
        @(posedge clock);
        #1;
        UARTCtrl = 1'b0;
        ioRead   = 1'b0;
        uartAddr = 2'b00;
    endtask

    initial begin
        //        send  byte   stop sel  rd   addr   exp
        vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'b10, 16'h0000};
        vecs[2]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 2'b00, 16'h005A};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'b10, 16'h0000};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'b01, 16'h0000};
        vecs[5]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 2'b11, 16'h0000};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'b00, 16'h0000};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0000};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'b10, 16'h0001};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'b00, 16'h0033};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'b00, 16'h0000};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'b10, 16'h0000};
        vecs[12] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 2'b10, 16'h0008};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'b10, 16'h0000};
        vecs[14] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 2'b00, 16'h0000};
        vecs[15] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 2'b10, 16'h0009};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'b00, 16'h0011};
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'b10, 16'h0000};
        vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 2'b00, 16'h0000};

        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        for (int v = 0; v < NV; v++) begin
            if (vecs[v].send) send_frame(vecs[v].byte_v, vecs[v].stop_v);
            do_read(vecs[v].sel, vecs[v].rd, vecs[v].addr, vecs[v].exp,
                    $sformatf("vec%0d", v));
        end

        // Short low pulse must be rejected as a glitch.
        @(negedge clock);
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (30) @(negedge clock);
        do_read(1'b1, 1'b1, 2'b10, 16'h0000, "glitch_status");
        do_read(1'b1, 1'b1, 2'b00, 16'h0000, "glitch_data");

        // Nine frames into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
        do_read(1'b1, 1'b1, 2'b10, 16'h0007, "ovr_status");
        for (int i = 1; i <= 8; i++)
            do_read(1'b1, 1'b1, 2'b00, 16'(i), $sformatf("ovr_data%0d", i));
        do_read(1'b1, 1'b1, 2'b10, 16'h0000, "ovr_status_after");

        // Full FIFO, DATA read in the exact cycle of the stop-bit push.
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1);
        fork
            send_frame(8'h18, 1'b1);
            begin
                @(negedge clock);
                repeat (155) @(posedge clock);
                do_read(1'b1, 1'b1, 2'b00, 16'h0010, "coll_data");
            end
        join
        do_read(1'b1, 1'b1, 2'b10, 16'h0003, "coll_status");
        for (int i = 1; i <= 8; i++)
            do_read(1'b1, 1'b1, 2'b00, 16'h0010 + 16'(i), $sformatf("coll_data%0d", i));
        do_read(1'b1, 1'b1, 2'b10, 16'h0000, "coll_status_after");

        // Reset in the middle of data bit 3, with a byte already queued.
        send_frame(8'h77, 1'b1);
        @(negedge clock);
        rx = 1'b0;
        repeat (16) @(negedge clock);
        rx = 1'b1; repeat (16) @(negedge clock);
        rx = 1'b1; repeat (16) @(negedge clock);
        rx = 1'b0; repeat (16) @(negedge clock);
        rx = 1'b0; repeat (8)  @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        rx = 1'b1;
        reset = 1'b0;
        repeat (20) @(negedge clock);
        do_read(1'b1, 1'b1, 2'b10, 16'h0000, "rst_status");
        send_frame(8'hC3, 1'b1);
        do_read(1'b1, 1'b1, 2'b00, 16'h00C3, "rst_data");
        do_read(1'b1, 1'b1, 2'b10, 16'h0000, "rst_status_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
